// File: rtl/neuron_sched_pkg.sv
// Shared types and constants for the neuron update scheduler.
// Holds the sweep FSM encoding, default membrane parameters and a width helper.
package neuron_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        EMIT  = 3'd4,
        NEXT  = 3'd5
    } sched_state_e;

    localparam int DEF_V_W     = 16;
    localparam int DEF_V_RESET = -65;

    // Ceiling log2; clog2(1) is 0, so callers needing a nonzero width clamp it.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/neuron_update_scheduler_state_bank.sv
// Per-neuron membrane potential and refractory count register file.
// One combinational read port, one V+refr write port and a refr-decrement port.
module neuron_state_bank
    import neuron_sched_pkg::*;
#(
    parameter int N       = 4,
    parameter int V_W     = DEF_V_W,
    parameter int V_RESET = DEF_V_RESET,
    parameter int R_W     = 2,
    parameter int ID_W    = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [ID_W-1:0] rd_idx_i,
    output logic [V_W-1:0]  rd_v_o,
    output logic [R_W-1:0]  rd_refr_o,
    input  logic            wr_en_i,
    input  logic [ID_W-1:0] wr_idx_i,
    input  logic [V_W-1:0]  wr_v_i,
    input  logic [R_W-1:0]  wr_refr_i,
    input  logic            dec_en_i,
    input  logic [ID_W-1:0] dec_idx_i
);

    logic [V_W-1:0] v_all    [N];
    logic [R_W-1:0] refr_all [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slot
            logic [V_W-1:0] v_q;
            logic [V_W-1:0] v_d;
            logic [R_W-1:0] refr_q;
            logic [R_W-1:0] refr_d;

            // A write and a decrement never target the same cycle; write still wins.
            always_comb begin
                v_d    = v_q;
                refr_d = refr_q;
                if (wr_en_i && (wr_idx_i == ID_W'(gi))) begin
                    v_d    = wr_v_i;
                    refr_d = wr_refr_i;
                end else if (dec_en_i && (dec_idx_i == ID_W'(gi)) && (refr_q != '0)) begin
                    refr_d = refr_q - R_W'(1);
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    v_q    <= V_W'(V_RESET);
                    refr_q <= '0;
                end else begin
                    v_q    <= v_d;
                    refr_q <= refr_d;
                end
            end

            assign v_all[gi]    = v_q;
            assign refr_all[gi] = refr_q;
        end
    endgenerate

    assign rd_v_o    = v_all[rd_idx_i];
    assign rd_refr_o = refr_all[rd_idx_i];

endmodule

// File: rtl/neuron_update_scheduler.sv
// Sweeps all neuron slots through one shared membrane-update datapath per tick,
// tracking refractory periods and forwarding spikes over a valid/ready port.
module neuron_update_scheduler
    import neuron_sched_pkg::*;
#(
    parameter int  N_NEURONS     = 4,
    parameter int  V_W           = DEF_V_W,
    parameter int  V_RESET       = DEF_V_RESET,
    parameter int  REFRACT_TICKS = 2,
    localparam int ID_W          = clog2(N_NEURONS)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   tick_in,
    input  logic [7:0]             dt,
    input  logic [8*N_NEURONS-1:0] current_in,
    output logic                   dp_req_valid,
    input  logic                   dp_req_ready,
    output logic [ID_W-1:0]        dp_id,
    output logic [V_W-1:0]         dp_v,
    output logic [7:0]             dp_current,
    output logic [7:0]             dp_dt,
    input  logic                   dp_rsp_valid,
    input  logic [V_W-1:0]         dp_v_next,
    input  logic                   dp_spike,
    output logic                   spike_valid,
    input  logic                   spike_ready,
    output logic [ID_W-1:0]        spike_id,
    output logic                   busy,
    output logic                   overrun
);

    localparam int R_W_RAW = clog2(REFRACT_TICKS + 1);
    localparam int R_W     = (R_W_RAW < 1) ? 1 : R_W_RAW;

    sched_state_e           state_q, state_d;
    logic [ID_W-1:0]        idx_q, idx_d;
    logic [8*N_NEURONS-1:0] cur_q, cur_d;
    logic [7:0]             dt_q, dt_d;
    logic                   overrun_q, overrun_d;

    logic [V_W-1:0] rd_v;
    logic [R_W-1:0] rd_refr;
    logic           wr_en;
    logic [V_W-1:0] wr_v;
    logic [R_W-1:0] wr_refr;
    logic           dec_en;

    neuron_state_bank #(
        .N       (N_NEURONS),
        .V_W     (V_W),
        .V_RESET (V_RESET),
        .R_W     (R_W),
        .ID_W    (ID_W)
    ) u_bank (
        .clock     (clock),
        .reset     (reset),
        .rd_idx_i  (idx_q),
        .rd_v_o    (rd_v),
        .rd_refr_o (rd_refr),
        .wr_en_i   (wr_en),
        .wr_idx_i  (idx_q),
        .wr_v_i    (wr_v),
        .wr_refr_i (wr_refr),
        .dec_en_i  (dec_en),
        .dec_idx_i (idx_q)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cur_d     = cur_q;
        dt_d      = dt_q;
        overrun_d = overrun_q;
        wr_en     = 1'b0;
        wr_v      = dp_v_next;
        wr_refr   = '0;
        dec_en    = 1'b0;

        // Any tick that is not accepted in IDLE is lost; remember that it happened.
        if (tick_in && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (tick_in) begin
                    cur_d   = current_in;
                    dt_d    = dt;
                    idx_d   = '0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (rd_refr != '0) begin
                    dec_en  = 1'b1;
                    state_d = NEXT;
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (dp_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (dp_rsp_valid) begin
                    wr_en = 1'b1;
                    if (dp_spike) begin
                        wr_v    = V_W'(V_RESET);
                        wr_refr = R_W'(REFRACT_TICKS);
                        state_d = EMIT;
                    end else begin
                        state_d = NEXT;
                    end
                end
            end
            EMIT: begin
                if (spike_ready) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (idx_q == ID_W'(N_NEURONS - 1)) begin
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + ID_W'(1);
                    state_d = CHECK;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cur_q     <= '0;
            dt_q      <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cur_q     <= cur_d;
            dt_q      <= dt_d;
            overrun_q <= overrun_d;
        end
    end

    assign dp_req_valid = (state_q == ISSUE);
    assign dp_id        = idx_q;
    assign dp_v         = rd_v;
    assign dp_current   = cur_q[8*idx_q +: 8];
    assign dp_dt        = dt_q;
    assign spike_valid  = (state_q == EMIT);
    assign spike_id     = idx_q;
    assign busy         = (state_q != IDLE);
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_neuron_update_scheduler.sv
// Directed scoreboard bench for neuron_update_scheduler: the bench models V and
// refractory state, queues expected requests/spikes per tick and checks them on handshake.
module tb_neuron_update_scheduler;

    logic        clock;
    logic        reset;
    logic        tick_in;
    logic [7:0]  dt;
    logic [31:0] current_in;
    logic        dp_req_valid;
    logic        dp_req_ready;
    logic [1:0]  dp_id;
    logic [15:0] dp_v;
    logic [7:0]  dp_current;
    logic [7:0]  dp_dt;
    logic        dp_rsp_valid;
    logic [15:0] dp_v_next;
    logic        dp_spike;
    logic        spike_valid;
    logic        spike_ready;
    logic [1:0]  spike_id;
    logic        busy;
    logic        overrun;

    neuron_update_scheduler #(
        .N_NEURONS     (4),
        .V_W           (16),
        .V_RESET       (-65),
        .REFRACT_TICKS (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .tick_in      (tick_in),
        .dt           (dt),
        .current_in   (current_in),
        .dp_req_valid (dp_req_valid),
        .dp_req_ready (dp_req_ready),
        .dp_id        (dp_id),
        .dp_v         (dp_v),
        .dp_current   (dp_current),
        .dp_dt        (dp_dt),
        .dp_rsp_valid (dp_rsp_valid),
        .dp_v_next    (dp_v_next),
        .dp_spike     (dp_spike),
        .spike_valid  (spike_valid),
        .spike_ready  (spike_ready),
        .spike_id     (spike_id),
        .busy         (busy),
        .overrun      (overrun)
    );

    localparam logic [15:0] V_RST = 16'hFFBF;  // -65

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] v;
        logic [7:0]  cur;
        logic [7:0]  dtv;
        logic        spike;
    } req_t;

    req_t        exp_q[$];
    logic [1:0]  spk_q[$];
    logic [15:0] m_v [4];
    int          m_refr [4];
    logic        m_ovr;
    int          n_cmp;
    int          n_fail;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_v[k]    = V_RST;
            m_refr[k] = 0;
        end
        m_ovr = 1'b0;
        exp_q.delete();
        spk_q.delete();
    endtask

    // One tick plus the whole sweep; the bench acts as datapath and spike sink.
    task automatic do_sweep(input logic [31:0] cur, input logic [7:0] dtv, input logic [3:0] mask,
                            input int rstall, input int sstall, input int ovr_at);
        int   exp_busy, exp_reqv, exp_spkv, busy_cyc, reqv_cyc, spkv_cyc, rs, ss;
        bit   pending, first_req, first_spk;
        req_t e, pend;
        exp_busy = 0; exp_reqv = 0; exp_spkv = 0;
        first_req = 1'b1; first_spk = 1'b1;
        pend = '0;
        for (int k = 0; k < 4; k++) begin
            if (m_refr[k] != 0) begin
                m_refr[k] = m_refr[k] - 1;
                exp_busy += 2;
            end else begin
                e.id = 2'(k); e.v = m_v[k]; e.cur = cur[8*k +: 8]; e.dtv = dtv; e.spike = mask[k];
                exp_q.push_back(e);
                exp_busy += 4; exp_reqv += 1;
                if (first_req) begin
                    exp_busy += rstall; exp_reqv += rstall; first_req = 1'b0;
                end
                if (mask[k]) begin
                    m_v[k] = V_RST; m_refr[k] = 2;
                    spk_q.push_back(2'(k));
                    exp_busy += 1; exp_spkv += 1;
                    if (first_spk) begin
                        exp_busy += sstall; exp_spkv += sstall; first_spk = 1'b0;
                    end
                end else begin
                    m_v[k] = m_v[k] + {8'h00, e.cur};
                end
            end
        end

        @(negedge clock);
        current_in = cur; dt = dtv; tick_in = 1'b1;
        busy_cyc = 0; reqv_cyc = 0; spkv_cyc = 0; pending = 1'b0; rs = rstall; ss = sstall;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clock);
            tick_in = (cyc == ovr_at);
            if (cyc == ovr_at) begin
                current_in = 32'hA5A5A5A5; dt = 8'h5A;
            end
            if (busy !== 1'b1) begin
                tick_in = 1'b0;
                break;
            end
            busy_cyc++;
            dp_rsp_valid = 1'b0; dp_spike = 1'b0;
            if (pending) begin
                dp_rsp_valid = 1'b1;
                dp_v_next    = pend.v + {8'h00, pend.cur};
                dp_spike     = pend.spike;
                pending      = 1'b0;
            end
            dp_req_ready = 1'b1;
            if (dp_req_valid) begin
                reqv_cyc++;
                if (exp_q.size() == 0) begin
                    check("unexpected_req", 32'(dp_req_valid), 32'd0);
                end else begin
                    e = exp_q[0];
                    check("req_id", 32'(dp_id), 32'(e.id));
                    check("req_v", 32'(dp_v), 32'(e.v));
                    check("req_cur", 32'(dp_current), 32'(e.cur));
                    check("req_dt", 32'(dp_dt), 32'(e.dtv));
                    if (rs > 0) begin
                        rs--;
                        dp_req_ready = 1'b0;
                    end else begin
                        void'(exp_q.pop_front());
                        $display("req id=%0d v=%0d cur=%0d dt=%0d", dp_id, $signed(dp_v), dp_current, dp_dt);
                        pend = e; pending = 1'b1;
                    end
                end
            end
            spike_ready = 1'b1;
            if (spike_valid) begin
                spkv_cyc++;
                check("emit_no_req", 32'(dp_req_valid), 32'd0);
                if (spk_q.size() == 0) begin
                    check("unexpected_spike", 32'(spike_valid), 32'd0);
                end else begin
                    check("spike_id", 32'(spike_id), 32'(spk_q[0]));
                    if (ss > 0) begin
                        ss--;
                        spike_ready = 1'b0;
                    end else begin
                        void'(spk_q.pop_front());
                        $display("spike id=%0d", spike_id);
                    end
                end
            end
        end
        tick_in = 1'b0; dp_rsp_valid = 1'b0; dp_spike = 1'b0;
        dp_req_ready = 1'b1; spike_ready = 1'b1;

        check("sweep_done", 32'(busy), 32'd0);
        check("busy_cycles", 32'(busy_cyc), 32'(exp_busy));
        check("req_valid_cycles", 32'(reqv_cyc), 32'(exp_reqv));
        check("spike_valid_cycles", 32'(spkv_cyc), 32'(exp_spkv));
        check("req_queue_left", 32'(exp_q.size()), 32'd0);
        check("spike_queue_left", 32'(spk_q.size()), 32'd0);
        check("idle_id", 32'(dp_id), 32'd3);
        check("idle_v", 32'(dp_v), 32'(m_v[3]));
        exp_q.delete();
        spk_q.delete();
        @(negedge clock);
        check("no_extra_sweep", 32'(busy), 32'd0);
        if (ovr_at >= 0) m_ovr = 1'b1;
        check("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        reset = 1'b1; tick_in = 1'b0; dt = 8'd0; current_in = '0;
        dp_req_ready = 1'b1; dp_rsp_valid = 1'b0; dp_v_next = '0; dp_spike = 1'b0;
        spike_ready = 1'b1;
        model_reset();

        // Reset, with a tick coinciding with the last reset cycle.
        repeat (3) @(negedge clock);
        tick_in = 1'b1; current_in = 32'h11223344; dt = 8'd9;
        @(negedge clock);
        reset = 1'b0; tick_in = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_valid", 32'(dp_req_valid), 32'd0);
        check("rst_spike_valid", 32'(spike_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_dp_v", 32'(dp_v), 32'(V_RST));
        check("rst_dp_id", 32'(dp_id), 32'd0);
        check("rst_dp_current", 32'(dp_current), 32'd0);
        check("rst_dp_dt", 32'(dp_dt), 32'd0);
        check("rst_spike_id", 32'(spike_id), 32'd0);
        @(negedge clock);
        check("rst_tick_dropped", 32'(busy), 32'd0);

        // Plain sweep, backpressure, spike with stalled sink, overrun, refractory skips.
        do_sweep(32'h281E140A, 8'd1, 4'b0000, 0, 0, -1);
        do_sweep(32'h04030201, 8'd2, 4'b0000, 5, 0, -1);
        do_sweep(32'h05050505, 8'd3, 4'b0100, 0, 3, -1);
        do_sweep(32'h06060606, 8'd4, 4'b0000, 0, 0, 3);
        do_sweep(32'h07070707, 8'd5, 4'b0000, 0, 0, -1);
        do_sweep(32'h08080808, 8'd6, 4'b0000, 0, 0, -1);

        // Reset while waiting for a response, then a late response.
        @(negedge clock);
        current_in = 32'h09090909; dt = 8'd7; tick_in = 1'b1;
        @(negedge clock);
        tick_in = 1'b0;
        check("mid_check_busy", 32'(busy), 32'd1);
        @(negedge clock);
        check("mid_issue_valid", 32'(dp_req_valid), 32'd1);
        @(negedge clock);
        check("mid_wait_busy", 32'(busy), 32'd1);
        check("mid_wait_no_req", 32'(dp_req_valid), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_spike_valid", 32'(spike_valid), 32'd0);
        check("mid_rst_overrun", 32'(overrun), 32'd0);
        check("mid_rst_dp_v", 32'(dp_v), 32'(V_RST));
        dp_rsp_valid = 1'b1; dp_v_next = 16'h1234; dp_spike = 1'b1;
        @(negedge clock);
        dp_rsp_valid = 1'b0; dp_spike = 1'b0;
        check("late_rsp_busy", 32'(busy), 32'd0);
        check("late_rsp_spike_valid", 32'(spike_valid), 32'd0);
        check("late_rsp_dp_v", 32'(dp_v), 32'(V_RST));
        model_reset();

        // All V back at rest; then every neuron spikes and the next sweep skips all of them.
        do_sweep(32'h01010101, 8'd1, 4'b0000, 0, 0, -1);
        do_sweep(32'h02020202, 8'd1, 4'b1111, 0, 0, -1);
        do_sweep(32'h03030303, 8'd1, 4'b0000, 0, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
